// File: rtl/rect_drop_ctl.sv
// rtl/rect_drop_ctl.sv - mouse-driven rectangle that can be grabbed, dropped under gravity and lands
module rect_drop_ctl #(
    parameter int SCREEN_WIDTH  = 800,
    parameter int SCREEN_HEIGHT = 600,
    parameter int RECT_WIDTH    = 48,
    parameter int RECT_HEIGHT   = 64,
    parameter int G_STEP        = 1,
    parameter int V_MAX         = 16,
    parameter int LAND_FRAMES   = 60
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vsync_start,
    input  logic        mouse_left,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        falling,
    output logic        landed
);

    localparam logic [11:0] XMAX  = 12'(SCREEN_WIDTH - RECT_WIDTH);
    localparam logic [11:0] YMAX  = 12'(SCREEN_HEIGHT - RECT_HEIGHT);
    localparam logic [11:0] GSTEP = 12'(G_STEP);
    localparam logic [11:0] VMAX  = 12'(V_MAX);
    localparam int          CW    = (LAND_FRAMES < 1) ? 1 : $clog2(LAND_FRAMES + 1);
    localparam logic [CW-1:0] LAND_CNT = CW'(LAND_FRAMES);

    typedef enum logic [1:0] {FOLLOW, HOLD, FALL, LANDED} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [11:0]   vel;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [12:0]   vel_sum;
    logic [11:0]   vel_new;
    logic [12:0]   y_sum;
    logic [11:0]   y_fall;
    logic [11:0]   x_clamp;
    logic [11:0]   y_clamp;

    // Gravity step and clamped pointer position; sums are 13 bits so nothing wraps
    always_comb begin
        vel_sum = {1'b0, vel} + {1'b0, GSTEP};
        vel_new = (vel_sum > {1'b0, VMAX}) ? VMAX : vel_sum[11:0];
        y_sum   = {1'b0, ypos} + {1'b0, vel_new};
        y_fall  = (y_sum >= {1'b0, YMAX}) ? YMAX : y_sum[11:0];
        x_clamp = (mouse_xpos > XMAX) ? XMAX : mouse_xpos;
        y_clamp = (mouse_ypos > YMAX) ? YMAX : mouse_ypos;
        cnt_inc = cnt + CW'(1);
    end

    // Next-state logic; a button press always wins over landing or timeout
    always_comb begin
        state_nxt = state;
        case (state)
            FOLLOW: if (mouse_left) state_nxt = HOLD;
            HOLD:   if (!mouse_left) state_nxt = FALL;
            FALL: begin
                if (mouse_left)
                    state_nxt = HOLD;
                else if (vsync_start && (y_fall == YMAX))
                    state_nxt = LANDED;
            end
            LANDED: begin
                if (mouse_left)
                    state_nxt = HOLD;
                else if (vsync_start && (cnt_inc == LAND_CNT))
                    state_nxt = FOLLOW;
            end
            default: state_nxt = FOLLOW;
        endcase
    end

    // State register with status flags decoded from the next state
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state   <= FOLLOW;
            falling <= 1'b0;
            landed  <= 1'b0;
        end else begin
            state   <= state_nxt;
            falling <= (state_nxt == FALL);
            landed  <= (state_nxt == LANDED);
        end
    end

    // Per-frame position update driven by the state the frame started in
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            xpos <= '0;
            ypos <= '0;
        end else if (vsync_start) begin
            case (state)
                FOLLOW, HOLD: begin
                    xpos <= x_clamp;
                    ypos <= y_clamp;
                end
                FALL:    ypos <= y_fall;
                default: ;
            endcase
        end
    end

    // Velocity lives only while falling continues; landing counter only while landed
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vel <= '0;
            cnt <= '0;
        end else begin
            if ((state == FALL) && (state_nxt == FALL)) begin
                if (vsync_start)
                    vel <= vel_new;
            end else begin
                vel <= '0;
            end
            if (state == LANDED) begin
                if (vsync_start)
                    cnt <= cnt_inc;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rect_drop_ctl.sv
// tb/tb_rect_drop_ctl.sv - self-checking bench for rect_drop_ctl
module tb_rect_drop_ctl;

    localparam int XMAX = 752;
    localparam int YMAX = 536;
    localparam int VMAX = 16;
    localparam int GS   = 1;
    localparam int LF   = 60;

    localparam int M_FOLLOW = 0;
    localparam int M_HOLD   = 1;
    localparam int M_FALL   = 2;
    localparam int M_LANDED = 3;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync_start = 1'b0;
    logic        mouse_left = 1'b0;
    logic [11:0] mouse_xpos = '0;
    logic [11:0] mouse_ypos = '0;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        falling;
    logic        landed;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    int m_mode, m_x, m_y, m_vel, m_cnt;
    int fall_y[8] = '{501, 503, 506, 510, 515, 521, 528, 536};

    rect_drop_ctl dut (
        .pclk       (pclk),
        .rst        (rst),
        .vsync_start(vsync_start),
        .mouse_left (mouse_left),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .xpos       (xpos),
        .ypos       (ypos),
        .falling    (falling),
        .landed     (landed)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_mode = M_FOLLOW;
        m_x = 0; m_y = 0; m_vel = 0; m_cnt = 0;
    endtask

    // Drive one cycle of inputs; the model predicts the state after the coming edge
    task automatic step(input bit vs, input bit ml, input int mx, input int my);
        int mode, x, y, vel, cnt;
        vsync_start = vs;
        mouse_left  = ml;
        mouse_xpos  = 12'(mx);
        mouse_ypos  = 12'(my);
        mode = m_mode; x = m_x; y = m_y; vel = m_vel; cnt = m_cnt;
        if (vs) begin
            if (m_mode == M_FOLLOW || m_mode == M_HOLD) begin
                x = imin(mx, XMAX);
                y = imin(my, YMAX);
                vel = 0;
            end else if (m_mode == M_FALL) begin
                vel = imin(vel + GS, VMAX);
                y = imin(y + vel, YMAX);
            end else begin
                cnt = cnt + 1;
            end
        end
        if (m_mode == M_FOLLOW) begin
            if (ml) mode = M_HOLD;
        end else if (m_mode == M_HOLD) begin
            if (!ml) begin mode = M_FALL; vel = 0; end
        end else if (m_mode == M_FALL) begin
            if (ml) begin mode = M_HOLD; vel = 0; end
            else if (vs && y == YMAX) begin mode = M_LANDED; cnt = 0; end
        end else begin
            if (ml) mode = M_HOLD;
            else if (vs && cnt == LF) mode = M_FOLLOW;
        end
        @(posedge pclk);
        #1;
        m_mode = mode; m_x = x; m_y = y; m_vel = vel; m_cnt = cnt;
        vsync_start = 1'b0;
    endtask

    task automatic frame(input bit ml, input int mx, input int my);
        step(1'b1, ml, mx, my);
        step(1'b0, ml, mx, my);
    endtask

    // Continuous comparison of every DUT output against the model
    always @(negedge pclk) begin
        if (check_en) begin
            chk("cmp_xpos", int'(xpos), m_x);
            chk("cmp_ypos", int'(ypos), m_y);
            chk("cmp_falling", int'(falling), (m_mode == M_FALL) ? 1 : 0);
            chk("cmp_landed", int'(landed), (m_mode == M_LANDED) ? 1 : 0);
        end
    end

    initial begin
        bit ml;
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        rst = 1'b0;
        check_en = 1'b1;
        chk("rst_xpos", int'(xpos), 0);
        chk("rst_ypos", int'(ypos), 0);
        chk("rst_falling", int'(falling), 0);
        chk("rst_landed", int'(landed), 0);

        step(1'b1, 1'b0, 100, 200);
        chk("follow_x", int'(xpos), 100);
        chk("follow_y", int'(ypos), 200);
        chk("follow_falling", int'(falling), 0);
        chk("follow_landed", int'(landed), 0);

        step(1'b1, 1'b0, 900, 700);
        chk("clamp_x", int'(xpos), 752);
        chk("clamp_y", int'(ypos), 536);

        step(1'b0, 1'b1, 100, 500);
        step(1'b1, 1'b1, 100, 500);
        chk("hold_y", int'(ypos), 500);
        step(1'b0, 1'b0, 100, 500);
        chk("release_falling", int'(falling), 1);
        for (int i = 0; i < 8; i++) begin
            frame(1'b0, 100, 500);
            chk("fall_y", int'(ypos), fall_y[i]);
        end
        chk("land_landed", int'(landed), 1);
        chk("land_falling", int'(falling), 0);

        for (int i = 0; i < LF - 1; i++) frame(1'b0, 10, 20);
        chk("timeout_59_landed", int'(landed), 1);
        frame(1'b0, 10, 20);
        chk("timeout_60_landed", int'(landed), 0);
        chk("timeout_60_falling", int'(falling), 0);
        chk("timeout_held_x", int'(xpos), 100);
        chk("timeout_held_y", int'(ypos), 536);
        step(1'b1, 1'b0, 10, 20);
        chk("refollow_x", int'(xpos), 10);
        chk("refollow_y", int'(ypos), 20);

        step(1'b0, 1'b1, 100, 530);
        step(1'b1, 1'b1, 100, 530);
        step(1'b0, 1'b0, 100, 530);
        repeat (3) frame(1'b0, 100, 530);
        chk("land2_landed", int'(landed), 1);
        repeat (30) frame(1'b0, 100, 530);
        chk("frame30_landed", int'(landed), 1);
        step(1'b0, 1'b1, 200, 300);
        chk("press30_landed", int'(landed), 0);
        chk("press30_xpos", int'(xpos), 100);
        step(1'b1, 1'b1, 200, 300);
        chk("press30_hold_x", int'(xpos), 200);
        chk("press30_hold_y", int'(ypos), 300);

        step(1'b0, 1'b1, 50, 0);
        step(1'b1, 1'b1, 50, 0);
        step(1'b0, 1'b0, 50, 0);
        for (int i = 1; i <= 17; i++) begin
            frame(1'b0, 50, 0);
            if (i == 16) chk("vcap_16", int'(ypos), 136);
            if (i == 17) chk("vcap_17", int'(ypos), 152);
        end

        step(1'b0, 1'b1, 100, 500);
        step(1'b1, 1'b1, 100, 500);
        step(1'b0, 1'b0, 100, 500);
        repeat (4) frame(1'b0, 100, 500);
        chk("regrab_pre_y", int'(ypos), 510);
        step(1'b0, 1'b1, 300, 50);
        chk("regrab_falling", int'(falling), 0);
        chk("regrab_y_unmoved", int'(ypos), 510);
        step(1'b1, 1'b1, 300, 50);
        chk("regrab_x", int'(xpos), 300);
        chk("regrab_y", int'(ypos), 50);
        step(1'b0, 1'b0, 300, 50);
        step(1'b1, 1'b0, 300, 50);
        chk("regrab_v1_y", int'(ypos), 51);

        step(1'b1, 1'b0, 300, 50);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_x", int'(xpos), 0);
        chk("async_rst_y", int'(ypos), 0);
        chk("async_rst_falling", int'(falling), 0);
        chk("async_rst_landed", int'(landed), 0);
        @(posedge pclk);
        #1;
        rst = 1'b0;
        step(1'b1, 1'b0, 77, 88);
        chk("post_rst_x", int'(xpos), 77);
        chk("post_rst_y", int'(ypos), 88);

        ml = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) ml = ~ml;
            step(($urandom_range(0, 2) == 0), ml,
                 int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        end

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rect_drop_ctl.md
RECT_DROP_CTL -- requirements
Module: rect_drop_ctl

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 800, meaning visible pixels per line.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 600, meaning visible lines per frame.
REQ-003 SHALL have parameter RECT_WIDTH, default 48, meaning rectangle width in pixels.
REQ-004 SHALL have parameter RECT_HEIGHT, default 64, meaning rectangle height in pixels.
REQ-005 SHALL have parameter G_STEP, default 1, meaning velocity increment per frame.
REQ-006 SHALL have parameter V_MAX, default 16, meaning velocity ceiling in lines per frame.
REQ-007 SHALL have parameter LAND_FRAMES, default 60, meaning number of frames spent in LANDED before returning to FOLLOW.
REQ-008 SHALL have port pclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-009 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-010 SHALL have port vsync_start, input, 1 bit: one-cycle pulse at the start of vertical blank.
REQ-011 SHALL have port mouse_left, input, 1 bit: left button level, already synchronous to pclk.
REQ-012 SHALL have ports mouse_xpos and mouse_ypos, input, 12 bits each: pointer position.
REQ-013 SHALL have ports xpos and ypos, output, 12 bits each, registered: rectangle top-left position.
REQ-014 SHALL have port falling, output, 1 bit, registered: high exactly while in state FALL.
REQ-015 SHALL have port landed, output, 1 bit, registered: high exactly while in state LANDED.

Function
REQ-016 SHALL implement FSM states FOLLOW, HOLD, FALL and LANDED; XMAX = SCREEN_WIDTH-RECT_WIDTH, YMAX = SCREEN_HEIGHT-RECT_HEIGHT.
REQ-017 SHALL evaluate state transitions on every cycle; SHALL change xpos, ypos, velocity and the frame counter only in cycles where vsync_start=1.
REQ-018 Transitions: FOLLOW->HOLD on mouse_left=1; HOLD->FALL on mouse_left=0; FALL->HOLD on mouse_left=1; FALL->LANDED when the updated ypos equals YMAX; LANDED->HOLD on mouse_left=1; LANDED->FOLLOW when the frame counter reaches LAND_FRAMES.
REQ-019 In a vsync_start cycle, the position update SHALL follow the current (pre-transition) state; the next state SHALL load on the same edge.
REQ-020 FOLLOW/HOLD update: xpos = min(mouse_xpos, XMAX), ypos = min(mouse_ypos, YMAX); velocity SHALL be 0.
REQ-021 FALL update: vel_new = min(vel+G_STEP, V_MAX); ypos = min(ypos+vel_new, YMAX), with the sum computed 13 bits wide (no wrap); xpos held.
REQ-022 On entry to FALL, velocity SHALL be 0; on FALL->HOLD, velocity SHALL clear to 0.
REQ-023 LANDED: position SHALL be held; the frame counter SHALL clear on entry and increment once per vsync_start; LANDED->HOLD SHALL take priority over the timeout.
REQ-024 falling and landed SHALL be registered decodes of the next state, aligned with the state register.
REQ-025 Output latency: xpos and ypos SHALL change on the clock edge that samples vsync_start=1 and SHALL be visible the following cycle.
REQ-026 mouse_left toggling with no vsync_start in between SHALL change state without moving the rectangle.

Reset
REQ-027 While rst=1: state=FOLLOW, xpos=0, ypos=0, velocity=0, frame counter=0, falling=0, landed=0, applied asynchronously, including mid-FALL.
REQ-028 After rst deasserts, the first vsync_start SHALL perform a FOLLOW update.

Verification
REQ-029 Reset, then mouse=(100,200) with one vsync_start -> xpos=100, ypos=200, falling=0, landed=0.
REQ-030 Clamp: mouse=(900,700) with vsync_start in FOLLOW -> xpos=752, ypos=536.
REQ-031 Fall: hold at (100,500), release, then 8 vsync_starts -> ypos 501,503,506,510,515,521,528,536; landed=1 and falling=0 after the 8th.
REQ-032 Velocity cap: release at ypos=0 -> ypos=136 after 16 frames and 152 after 17 (step stays 16).
REQ-033 Regrab mid-fall: press at ypos=510, mouse=(300,50), next vsync_start -> falling=0, xpos=300, ypos=50; release restarts at velocity 1.
REQ-034 Landed timeout: after landing, 60 vsync_starts with button released -> FOLLOW, landed=0; a press at frame 30 -> HOLD immediately; rst asserted mid-FALL -> all outputs 0 without waiting for a clock edge.
